// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO input-conditioning stage.
package gpio_pkg;

    localparam int unsigned GPIO_WIDTH_DEF = 32;
    localparam int unsigned DEBOUNCE_DEF   = 16;

    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;

    // True when an accepted level change matches the selected edge polarity.
    function automatic logic edge_event(input logic upd, input logic new_level, input logic sel);
        return upd & (((sel == EDGE_RISE) & new_level) | ((sel == EDGE_FALL) & ~new_level));
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: 2-flop synchronizer plus level acceptance; counter debounce when
// GPIO_IN_DEBOUNCE_EN is defined, otherwise the synchronized level passes straight through.
module gpio_debounce_bit
`ifdef GPIO_IN_DEBOUNCE_EN
    import gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    input  logic dir,
    output logic in_data,
    output logic upd_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic in_data_q, in_data_d;

    assign in_data = in_data_q;

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        sync1_d   = pin_in;
        sync2_d   = sync1_q;
        cnt_d     = cnt_q;
        in_data_d = in_data_q;
        upd_c     = 1'b0;
        if (dir || (sync2_q == in_data_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            in_data_d = sync2_q;
            cnt_d     = '0;
            upd_c     = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            in_data_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            in_data_q <= in_data_d;
            cnt_q     <= cnt_d;
        end
    end
`else
    always_comb begin
        sync1_d   = pin_in;
        sync2_d   = sync1_q;
        in_data_d = in_data_q;
        upd_c     = 1'b0;
        if (!dir && (sync2_q != in_data_q)) begin
            in_data_d = sync2_q;
            upd_c     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            in_data_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            in_data_q <= in_data_d;
        end
    end
`endif

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin sync/debounce, edge-triggered sticky status and irq.
// Debounce counters are built only when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = GPIO_WIDTH_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic [WIDTH-1:0] dir,
    input  logic [WIDTH-1:0] edge_sel,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    logic [WIDTH-1:0] upd_c;
    logic [WIDTH-1:0] evt_c;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;
    logic             irq_q, irq_d;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin
        gpio_debounce_bit
`ifdef GPIO_IN_DEBOUNCE_EN
        #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        )
`endif
        u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .pin_in  (gpio_in[i]),
            .dir     (dir[i]),
            .in_data (in_data[i]),
            .upd_c   (upd_c[i])
        );

        // An update always flips the level, so the new level is the inverse of the current one.
        assign evt_c[i] = edge_event(upd_c[i], ~in_data[i], edge_sel[i]);
    end

    // New events win over a coincident clear.
    always_comb begin
        irq_status_d = (irq_status_q & ~irq_clear) | evt_c;
        irq_d        = |(irq_status_q & irq_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= irq_d;
        end
    end

    assign irq_status = irq_status_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Self-checking bench for gpio_in_cond (WIDTH=8, DEBOUNCE_CYCLES=4) against a windowed reference model.
module tb_gpio_in_cond;

    localparam int W  = 8;
    localparam int DC = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int MD = DC;
`else
    localparam int MD = 1;
`endif
    // Edges from an input change (driven before edge 1) to the new in_data level.
    localparam int LAT = MD + 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] gpio_in, dir, edge_sel, irq_en, irq_clear;
    logic [W-1:0] in_data, irq_status;
    logic         irq;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0]  m_s1, m_s2, m_in, m_st;
    logic          m_irq;
    logic [MD-1:0] win [W];
    int            fill [W];

    gpio_in_cond #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gpio_in    (gpio_in),
        .dir        (dir),
        .edge_sel   (edge_sel),
        .irq_en     (irq_en),
        .irq_clear  (irq_clear),
        .in_data    (in_data),
        .irq_status (irq_status),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1  = '0;
        m_s2  = '0;
        m_in  = '0;
        m_st  = '0;
        m_irq = 1'b0;
        for (int i = 0; i < W; i++) begin
            win[i]  = '0;
            fill[i] = 0;
        end
    endtask

    // A pin's level flips once the last MD synchronized samples since the last
    // flip/mask all disagree with the current level.
    task automatic model_edge();
        logic [W-1:0] nxt, evt;
        nxt = m_in;
        evt = '0;
        for (int i = 0; i < W; i++) begin
            if (dir[i]) begin
                fill[i] = 0;
            end else begin
                win[i] = (win[i] << 1) | MD'(m_s2[i]);
                if (fill[i] < MD) fill[i]++;
                if (fill[i] == MD && win[i] == {MD{~m_in[i]}}) begin
                    nxt[i]  = ~m_in[i];
                    evt[i]  = (nxt[i] == edge_sel[i]);
                    fill[i] = 0;
                end
            end
        end
        m_irq = |(m_st & irq_en);
        m_st  = (m_st & ~irq_clear) | evt;
        m_in  = nxt;
        m_s2  = m_s1;
        m_s1  = gpio_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("in_data", in_data, m_in);
        chk("irq_status", irq_status, m_st);
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int  lat;
        bit  seen;

        rst_n     = 1'b0;
        gpio_in   = '0;
        dir       = '0;
        edge_sel  = 8'hFF;
        irq_en    = 8'hFF;
        irq_clear = '0;
        model_reset();

        #12;
        chk("rst_in_data", in_data, 8'h00);
        chk("rst_irq_status", irq_status, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);

        // All pins high across reset release; rising events on every pin
        gpio_in = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            step();
            if (in_data === 8'hFF) begin
                lat  = n;
                seen = 1'b1;
            end
        end
        chk("release_latency", 8'(lat), 8'(LAT));
        chk("release_status", irq_status, 8'hFF);
        step();
        chk("release_irq", {7'b0, irq}, 8'h01);

        irq_clear = 8'hFF;
        step();
        irq_clear = '0;
        gpio_in   = 8'h00;
        steps(10);

        // 3-sample glitch on pin0, then 1-sample pulse on pin1
        gpio_in = 8'h01;
        steps(3);
        gpio_in = 8'h00;
        steps(10);
        gpio_in = 8'h02;
        step();
        gpio_in = 8'h00;
        steps(10);
        irq_clear = 8'hFF;
        step();
        irq_clear = '0;

        // Pin3 falling-edge interrupt
        edge_sel = 8'hF7;
        irq_en   = 8'h08;
        gpio_in  = 8'h08;
        steps(10);
        gpio_in = 8'h00;
        steps(10);
        irq_clear = 8'h08;
        step();
        irq_clear = '0;
        steps(2);

        // Clear coinciding with a new set event: set wins
        gpio_in = 8'h08;
        steps(10);
        gpio_in = 8'h00;
        steps(LAT - 1);
        irq_clear = 8'h08;
        step();
        irq_clear = '0;
        chk("set_wins", {7'b0, irq_status[3]}, 8'h01);
        steps(3);
        irq_clear = 8'h08;
        step();
        irq_clear = '0;
        steps(2);

        // Pin5 masked as output while its input toggles
        edge_sel = 8'hFF;
        irq_en   = 8'hFF;
        dir      = 8'h20;
        for (int n = 0; n < 20; n++) begin
            gpio_in[5] = 1'($urandom_range(1, 0));
            step();
        end
        chk("dir_frozen", {7'b0, in_data[5]}, 8'h00);
        gpio_in[5] = 1'b1;
        dir        = 8'h00;
        steps(10);

        // Randomized traffic with a mid-run asynchronous reset
        for (int n = 0; n < 400; n++) begin
            gpio_in   = gpio_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            irq_clear = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if (n % 50 == 0)  dir      = 8'($urandom) & 8'($urandom);
            if (n % 37 == 0)  edge_sel = 8'($urandom);
            if (n % 29 == 0)  irq_en   = 8'($urandom);
            if (n == 200) begin
                rst_n = 1'b0;
                #2;
                chk("midrst_in_data", in_data, 8'h00);
                chk("midrst_irq_status", irq_status, 8'h00);
                chk("midrst_irq", {7'b0, irq}, 8'h00);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
